// File: rtl/srt4_ctrl.sv
// Control sequencer for the radix-4 SRT divider datapath: emits registered,
// single-cycle strobes c0..c14 separated by idle gap cycles.
module srt4_ctrl #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = 3
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    input  logic        b_msb,
    input  logic [2:0]  p_top,
    input  logic        p_sign,
    output logic [14:0] c,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    localparam int ITER_W = $clog2(N_BITS / 2 + 1);
    localparam logic [CNT_W-1:0]  K_MAX = CNT_W'(N_BITS - 1);
    localparam logic [ITER_W-1:0] ITERS = ITER_W'(N_BITS / 2);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] LOAD       = 4'd1;
    localparam logic [3:0] GAP        = 4'd2;
    localparam logic [3:0] NORM_CHK   = 4'd3;
    localparam logic [3:0] NORM_SHIFT = 4'd4;
    localparam logic [3:0] SEL        = 4'd5;
    localparam logic [3:0] SHIFT      = 4'd6;
    localparam logic [3:0] UPDATE     = 4'd7;
    localparam logic [3:0] ITER_CHK   = 4'd8;
    localparam logic [3:0] CORR_CHK   = 4'd9;
    localparam logic [3:0] CORR       = 4'd10;
    localparam logic [3:0] QFORM1     = 4'd11;
    localparam logic [3:0] QFORM2     = 4'd12;
    localparam logic [3:0] DENORM     = 4'd13;
    localparam logic [3:0] ERR        = 4'd14;
    localparam logic [3:0] DONE_ST    = 4'd15;

    logic [3:0]         state, nxt;
    logic [3:0]         ret, nxt_ret;
    logic [CNT_W-1:0]   k;
    logic [ITER_W-1:0]  iter;
    logic signed [2:0]  digit, digit_nxt;
    logic [14:0]        c_nxt;

    // Quotient digit from the top three bits of the partial remainder.
    function automatic logic signed [2:0] sel_digit(input logic [2:0] pt);
        case (pt)
            3'b001:         return 3'sd1;
            3'b010, 3'b011: return 3'sd2;
            3'b110:         return -3'sd1;
            3'b100, 3'b101: return -3'sd2;
            default:        return 3'sd0;
        endcase
    endfunction

    function automatic logic [14:0] strobes(input logic [3:0] st, input logic signed [2:0] d);
        logic [14:0] s;
        s = '0;
        case (st)
            LOAD:       s[1:0] = 2'b11;
            NORM_SHIFT: s[2] = 1'b1;
            SHIFT: begin
                s[3] = 1'b1;
                if (d == 3'sd1)       s[4] = 1'b1;
                else if (d == 3'sd2)  s[7] = 1'b1;
                else if (d == -3'sd1) s[5] = 1'b1;
                else if (d == -3'sd2) s[6] = 1'b1;
            end
            UPDATE: begin
                s[8]  = 1'b1;
                s[9]  = (d > 3'sd0);
                s[10] = (d == 3'sd2) || (d == -3'sd2);
            end
            CORR:    s[11] = 1'b1;
            QFORM1:  s[12] = 1'b1;
            QFORM2:  s[13] = 1'b1;
            DENORM:  s[14] = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    // Pulse states always detour through GAP; ret holds where GAP goes next.
    always_comb begin
        nxt     = state;
        nxt_ret = ret;
        case (state)
            IDLE:       if (start) nxt = LOAD;
            LOAD:       begin nxt = GAP; nxt_ret = NORM_CHK; end
            GAP:        nxt = ret;
            NORM_CHK: begin
                if (b_msb)         nxt = SEL;
                else if (k < K_MAX) nxt = NORM_SHIFT;
                else               nxt = ERR;
            end
            NORM_SHIFT: begin nxt = GAP; nxt_ret = NORM_CHK; end
            SEL:        nxt = SHIFT;
            SHIFT: begin
                nxt     = GAP;
                nxt_ret = (digit == 3'sd0) ? ITER_CHK : UPDATE;
            end
            UPDATE:     begin nxt = GAP; nxt_ret = ITER_CHK; end
            ITER_CHK:   nxt = (iter == ITERS) ? CORR_CHK : SEL;
            CORR_CHK:   nxt = p_sign ? CORR : QFORM1;
            CORR:       begin nxt = GAP; nxt_ret = QFORM1; end
            QFORM1:     begin nxt = GAP; nxt_ret = QFORM2; end
            QFORM2: begin
                nxt     = GAP;
                nxt_ret = (k == '0) ? DONE_ST : DENORM;
            end
            DENORM: begin
                nxt     = GAP;
                nxt_ret = (k > CNT_W'(1)) ? DENORM : DONE_ST;
            end
            ERR:        nxt = DONE_ST;
            DONE_ST:    nxt = IDLE;
            default:    nxt = IDLE;
        endcase
    end

    // The digit picked in SEL must already drive the SHIFT strobes it launches.
    always_comb begin
        digit_nxt = (state == SEL) ? sel_digit(p_top) : digit;
        c_nxt     = strobes(nxt, digit_nxt);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            ret         <= IDLE;
            c           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            k           <= '0;
            iter        <= '0;
            digit       <= 3'sd0;
        end else begin
            state <= nxt;
            ret   <= nxt_ret;
            c     <= c_nxt;
            digit <= digit_nxt;
            done  <= (nxt == DONE_ST);
            case (state)
                IDLE: if (start) begin
                    busy        <= 1'b1;
                    div_by_zero <= 1'b0;
                    k           <= '0;
                    iter        <= '0;
                end
                NORM_SHIFT: if (k < K_MAX) k <= k + 1'b1;
                SHIFT:      if (iter != ITERS) iter <= iter + 1'b1;
                DENORM:     if (k != '0) k <= k - 1'b1;
                ERR:        div_by_zero <= 1'b1;
                DONE_ST:    busy <= 1'b0;
                default:    ;
            endcase
        end
    end

endmodule

// File: tb/tb_srt4_ctrl.sv
// Directed bench for srt4_ctrl: a reactive datapath stand-in feeds b_msb/p_top/p_sign
// from observed strobe counts; strobe counts and sequences are checked per division.
module tb_srt4_ctrl;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        start = 1'b0;
    logic        b_msb = 1'b0;
    logic [2:0]  p_top = 3'd0;
    logic        p_sign = 1'b0;
    logic [14:0] c;
    logic        busy, done, div_by_zero;

    int checks = 0;
    int errors = 0;

    srt4_ctrl #(.N_BITS(8), .CNT_W(3)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .b_msb(b_msb),
        .p_top(p_top), .p_sign(p_sign), .c(c), .busy(busy),
        .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Scenario knobs
    int         nshift;
    logic [2:0] ptab [4];
    logic       psign_v;
    logic       stress;

    // Per-division observations
    int          cnt [15];
    int          done_cnt, overlap, c11_cyc, c12_cyc;
    logic [15:0] dig_log;
    logic [7:0]  upd_log;
    logic        busy_first, dbz_first, dbz_at_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        b_msb  = (cnt[2] >= nshift);
        p_top  = ptab[(cnt[3] > 3) ? 3 : cnt[3]];
        p_sign = psign_v;
    endtask

    task automatic run_div();
        logic [14:0] prev;
        int post;
        logic fin;
        for (int i = 0; i < 15; i++) cnt[i] = 0;
        done_cnt = 0; overlap = 0; c11_cyc = -1; c12_cyc = -1;
        dig_log = '0; upd_log = '0; dbz_at_done = 1'b0;
        prev = '0; post = 0; fin = 1'b0;
        drive_inputs();
        @(negedge clk) start = 1'b1;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                busy_first = busy;
                dbz_first  = div_by_zero;
            end
            if (!stress || cnt[3] >= 2) start = 1'b0;
            if ((prev & c) != '0) overlap++;
            for (int i = 0; i < 15; i++) if (c[i]) cnt[i]++;
            if (c[3]) dig_log = {dig_log[11:0], c[7:4]};
            if (c[8]) upd_log = {upd_log[5:0], c[10:9]};
            if (c[11] && c11_cyc < 0) c11_cyc = cyc;
            if (c[12] && c12_cyc < 0) c12_cyc = cyc;
            if (done) begin
                done_cnt++;
                dbz_at_done = div_by_zero;
            end
            if (done_cnt > 0) begin
                post++;
                if (post > 4) fin = 1'b1;
            end
            prev = c;
            drive_inputs();
        end
        start = 1'b0;
        if (!fin) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        ptab = '{3'd0, 3'd0, 3'd0, 3'd0};
        nshift = 0; psign_v = 1'b0; stress = 1'b0;

        #12;
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk) rst_b = 1'b1;
        repeat (2) @(negedge clk);

        // Normalized divisor, all-zero digits, start held high while busy
        stress = 1'b1;
        run_div();
        stress = 1'b0;
        chk("A_busy_first", 32'(busy_first), 32'd1);
        chk("A_c0", cnt[0], 1);
        chk("A_c1", cnt[1], 1);
        chk("A_c2", cnt[2], 0);
        chk("A_c14", cnt[14], 0);
        chk("A_c3", cnt[3], 4);
        chk("A_digits", 32'(dig_log), 32'h0);
        chk("A_c8", cnt[8], 0);
        chk("A_c11", cnt[11], 0);
        chk("A_c12", cnt[12], 1);
        chk("A_c13", cnt[13], 1);
        chk("A_done", done_cnt, 1);
        chk("A_overlap", overlap, 0);
        chk("A_busy_end", 32'(busy), 32'd0);

        // Three normalization shifts and one of each nonzero digit
        nshift = 3;
        ptab = '{3'b001, 3'b010, 3'b110, 3'b101};
        run_div();
        chk("B_c2", cnt[2], 3);
        chk("B_c14", cnt[14], 3);
        chk("B_c3", cnt[3], 4);
        chk("B_digits", 32'(dig_log), 32'h1824);
        chk("B_c8", cnt[8], 4);
        chk("B_updates", 32'(upd_log), 32'h72);
        chk("B_c11", cnt[11], 0);
        chk("B_done", done_cnt, 1);
        chk("B_overlap", overlap, 0);

        // Negative final remainder needs a correction step
        nshift = 1;
        ptab = '{3'd0, 3'd0, 3'd0, 3'd0};
        psign_v = 1'b1;
        run_div();
        psign_v = 1'b0;
        chk("C_c11", cnt[11], 1);
        chk("C_c11_before_c12", 32'(c11_cyc >= 0 && c11_cyc < c12_cyc), 32'd1);
        chk("C_c14", cnt[14], 1);
        chk("C_c2_eq_c14", 32'(cnt[2] == cnt[14]), 32'd1);
        chk("C_overlap", overlap, 0);

        // Zero divisor: never normalizes
        nshift = 99;
        run_div();
        chk("D_c2", cnt[2], 7);
        chk("D_c3", cnt[3], 0);
        chk("D_c12", cnt[12], 0);
        chk("D_c14", cnt[14], 0);
        chk("D_dbz", 32'(dbz_at_done), 32'd1);
        chk("D_done", done_cnt, 1);
        chk("D_dbz_held", 32'(div_by_zero), 32'd1);

        // Next start clears the error flag
        nshift = 0;
        run_div();
        chk("E_dbz_cleared", 32'(dbz_first), 32'd0);
        chk("E_c3", cnt[3], 4);

        // Asynchronous reset while in UPDATE
        begin
            int guard;
            int bad;
            nshift = 0;
            ptab = '{3'b010, 3'b010, 3'b010, 3'b010};
            for (int i = 0; i < 15; i++) cnt[i] = 0;
            drive_inputs();
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            guard = 0;
            while (!c[8] && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            chk("R_reached_update", 32'(c[8]), 32'd1);
            #1 rst_b = 1'b0;
            #1;
            chk("R_c_async", 32'(c), 32'd0);
            chk("R_busy_async", 32'(busy), 32'd0);
            @(negedge clk) rst_b = 1'b1;
            bad = 0;
            repeat (8) begin
                @(negedge clk);
                if (c != '0 || busy || done) bad++;
            end
            chk("R_quiet_after", bad, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/srt4_ctrl.md
Name: srt4_ctrl

Overview:
- Control sequencer for the 8-bit radix-4 SRT divider datapath; sits directly upstream of the P, A, A' and B registers.
- Drives their edge-triggered control strobes c0..c14 as clean single-cycle pulses from one clock.
- Handles operand load, divisor normalization, radix-4 quotient digit selection, iteration counting, final remainder correction, quotient formation (A - A') and remainder denormalization.

Parameters:
- N_BITS, 8, operand width. Iteration count is N_BITS/2; N_BITS must be even.
- CNT_W, 3, width of the normalization shift counter k; must be at least ceil(log2(N_BITS)).

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- start  input  1  begin a division; sampled only in IDLE.
- b_msb  input  1  B[N_BITS-1], used for normalization.
- p_top  input  3  P[8:6], top bits of the partial remainder, used for digit selection.
- p_sign  input  1  P[8], sign of the final remainder.
- c  output  15  control strobes; c[i] is strobe ci.
- busy  output  1  high from start acceptance until DONE.
- done  output  1  one-cycle pulse when the result is valid.
- div_by_zero  output  1  set on zero divisor; held until the next start.

Behaviour:
- Reset (async, rst_b=0): c=0, busy=0, done=0, div_by_zero=0, k=0, iter=0, state=IDLE. Reset in mid-operation drops every strobe in the same instant and aborts the operation.
- All outputs are registered, with no combinational path from inputs to c.
- Pulse rule:
  - Every strobe-asserting state lasts exactly 1 cycle and is always followed by one GAP cycle with c=0.
  - As a result, no strobe is high for two consecutive cycles, and downstream registers see one rising edge per action.
- Co-asserted strobes: secondary strobes (c1 with c0; c4..c7 with c3; c9/c10 with c8) rise in the same cycle as their primary strobe, so they are stable at its edge.
- States and transitions:
  - IDLE: start=1 -> LOAD; busy<=1, div_by_zero<=0, k<=0, iter<=0. start=0 stays in IDLE. start while busy is ignored.
  - LOAD: pulse c0|c1 (load A, clear P/A', load B). Next: NORM_CHK.
  - NORM_CHK (no pulse):
    - b_msb=1 -> SELECT.
    - b_msb=0 and k<N_BITS-1 -> NORM_SHIFT.
    - b_msb=0 and k==N_BITS-1 -> ERR.
  - NORM_SHIFT: pulse c2; k<=k+1. Next: NORM_CHK.
  - SELECT (no pulse): register digit from p_top:
    - 000, 111 -> 0
    - 001 -> +1
    - 010, 011 -> +2
    - 110 -> -1
    - 100, 101 -> -2
  - SHIFT: pulse c3 together with the digit strobe:
    - +1 -> c4
    - +2 -> c7
    - -1 -> c5
    - -2 -> c6
    - 0 -> none
    - iter<=iter+1.
  - After SHIFT: digit=0 -> ITER_CHK; otherwise -> UPDATE.
  - UPDATE: pulse c8, plus c9 if the digit is positive (subtract) and c10 if |digit|=2 (use 2B). Next: ITER_CHK.
  - ITER_CHK (no pulse): iter==N_BITS/2 -> CORR_CHK; otherwise -> SELECT.
  - CORR_CHK (no pulse): p_sign=1 -> CORR; otherwise -> QFORM1.
  - CORR: pulse c11 (restore remainder, quotient -1). Next: QFORM1.
  - QFORM1: pulse c12. Next: QFORM2.
  - QFORM2: pulse c13 (A<=A-A'). Next: k==0 -> DONE; otherwise -> DENORM.
  - DENORM: pulse c14; k<=k-1. Stays in DENORM (through GAP) while k>1 before the decrement; then DONE.
  - ERR: div_by_zero<=1, then DONE.
  - DONE: done=1 for one cycle, busy<=0. Next: IDLE.
- Counters:
  - k saturates at N_BITS-1 and never wraps.
  - iter counts 0..N_BITS/2; it is compared before any increment past the limit.
- Strobes that are never asserted by this block remain 0 at all times.
- Invariants:
  - Per division, c3 pulses exactly N_BITS/2 times (none on div_by_zero).
  - c2 count equals c14 count.

Test Plan:
- Reset during UPDATE -> c=0 and busy=0 immediately (asynchronously); after release, state=IDLE and no strobe fires until start.
- Divisor already normalized (b_msb=1 at NORM_CHK), p_top=000 every SELECT -> zero c2/c14 pulses, 4 c3 pulses with no c4..c7 and no c8, then c12, c13, done.
- b_msb goes to 1 after 3 c2 pulses; p_top sequence 001,010,110,101 -> c3 accompanied by c4, c7, c5, c6 in order. c8 sets: c9 alone; c9|c10; none; c10 alone. Exactly 3 c14 pulses, then done.
- p_sign=1 at CORR_CHK -> exactly one c11 pulse before c12; with p_sign=0 -> no c11.
- b_msb held 0 (zero divisor) -> exactly 7 c2 pulses, no c3, div_by_zero=1, one done pulse. The next start clears div_by_zero.
- Any run: no strobe is high for 2 consecutive cycles; start asserted while busy=1 has no effect.
